seg_display_scheduler: RTL and testbench

Owns the four-digit seven-segment display and schedules which status page it shows. Manual page stepping comes from one-cycle button pulses (next/prev). Any datapath block may pre-empt the display with a timed alert page. The block also multiplexes the four digits and performs hex-to-segment decoding.

---
 rtl/seg_disp_pkg.sv | 31 +++
 rtl/seg_digit_scanner.sv | 53 +++++
 rtl/seg_display_scheduler.sv | 120 ++++++++++++
 tb/tb_seg_display_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_disp_pkg
//  Description : Shared types, segment font and decode helper for the
//                seven-segment display scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_ALERT  = 2'd2
    } sched_state_t;

    localparam logic [6:0] c_seg_blank = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
    localparam logic [6:0] c_seg_font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return c_seg_font[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_digit_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg_digit_scanner
//  Description : Four-digit multiplexer with registered an/seg/dp outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_digit_scanner
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] c_refresh_last = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] r_refresh_cnt;
    logic [1:0]    r_digit;
    logic [3:0]    w_nibble;

    assign w_nibble = value[{r_digit, 2'b00} +: 4];

    // Outputs register the current digit, so each enable window is exactly
    // REFRESH_CYCLES long and lines up with the digit counter wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit       <= 2'd0;
            an            <= 4'b1111;
            seg           <= c_seg_blank;
            dp            <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << r_digit);
            seg <= hex_to_seg(w_nibble);
            dp  <= ~dp_mask[r_digit];
            if (r_refresh_cnt == c_refresh_last) begin
                r_refresh_cnt <= '0;
                r_digit       <= r_digit + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + RW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scheduler
//  Description : Page scheduler (manual stepping + timed alert pre-emption)
//                driving a four-digit seven-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int NUM_PAGES      = 4,
    parameter int REFRESH_CYCLES = 50000,
    parameter int ALERT_CYCLES   = 100000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_pulse,
    input  logic                         prev_pulse,
    input  logic                         alert_req,
    input  logic [$clog2(NUM_PAGES)-1:0] alert_page,
    input  logic [16*NUM_PAGES-1:0]      page_data,
    output logic [3:0]                   an,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic [$clog2(NUM_PAGES)-1:0] page_idx,
    output logic                         alert_active
);

    localparam int PW = $clog2(NUM_PAGES);
    localparam int AW = (ALERT_CYCLES > 1) ? $clog2(ALERT_CYCLES) : 1;
    localparam logic [AW-1:0] c_alert_reload = AW'(ALERT_CYCLES - 1);

    sched_state_t  r_state, w_state_nxt;
    logic [PW-1:0] r_manual_page, w_manual_nxt;
    logic [PW-1:0] r_shown_page, w_shown_nxt;
    logic [AW-1:0] r_alert_cnt, w_alert_cnt_nxt;
    logic [15:0]   w_page_word;
    logic [1:0]    w_dp_sel;
    logic [3:0]    w_dp_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RESET;
            r_manual_page <= '0;
            r_shown_page  <= '0;
            r_alert_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_manual_page <= w_manual_nxt;
            r_shown_page  <= w_shown_nxt;
            r_alert_cnt   <= w_alert_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_manual_nxt    = r_manual_page;
        w_shown_nxt     = r_shown_page;
        w_alert_cnt_nxt = r_alert_cnt;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_MANUAL;
                w_shown_nxt = r_manual_page;
            end
            ST_MANUAL: begin
                if (alert_req) begin
                    w_state_nxt     = ST_ALERT;
                    w_shown_nxt     = alert_page;
                    w_alert_cnt_nxt = c_alert_reload;
                end else if (next_pulse ^ prev_pulse) begin
                    w_manual_nxt = next_pulse ? r_manual_page + PW'(1)
                                              : r_manual_page - PW'(1);
                    w_shown_nxt  = w_manual_nxt;
                end
            end
            ST_ALERT: begin
                // A button press cancels the alert without stepping the page
                if (alert_req) begin
                    w_shown_nxt     = alert_page;
                    w_alert_cnt_nxt = c_alert_reload;
                end else if (next_pulse || prev_pulse || (r_alert_cnt == '0)) begin
                    w_state_nxt = ST_MANUAL;
                    w_shown_nxt = r_manual_page;
                end else begin
                    w_alert_cnt_nxt = r_alert_cnt - AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    generate
        if (PW >= 2) begin : g_dp_sel_wide
            assign w_dp_sel = r_shown_page[1:0];
        end else begin : g_dp_sel_narrow
            assign w_dp_sel = {1'b0, r_shown_page};
        end
    endgenerate

    assign w_page_word  = page_data[{r_shown_page, 4'b0000} +: 16];
    assign w_dp_mask    = (r_state == ST_ALERT) ? 4'b1111 : (4'b0001 << w_dp_sel);
    assign page_idx     = r_shown_page;
    assign alert_active = (r_state == ST_ALERT);

    seg_digit_scanner #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_scanner (
        .clk     (clk),
        .rst     (rst),
        .value   (w_page_word),
        .dp_mask (w_dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scheduler
//  Description : Directed + random bench for seg_display_scheduler with a
//                cycle-level behavioural model of pages, alerts and scanning.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scheduler;

    localparam int NP = 4;
    localparam int RC = 4;
    localparam int AC = 20;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst, next_pulse, prev_pulse, alert_req;
    logic [PW-1:0]     alert_page;
    logic [16*NP-1:0]  page_data;
    logic [3:0]        an;
    logic [6:0]        seg;
    logic              dp;
    logic [PW-1:0]     page_idx;
    logic              alert_active;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=reset, 1=manual, 2=alert
    int m_mode, m_man, m_shown, m_astart, cyc, sc;
    bit disp_valid, d_alert;
    int d_digit, d_page;
    logic [3:0] d_nib;
    logic [6:0] font [16];

    always #5 clk = ~clk;

    seg_display_scheduler #(
        .NUM_PAGES      (NP),
        .REFRESH_CYCLES (RC),
        .ALERT_CYCLES   (AC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .next_pulse   (next_pulse),
        .prev_pulse   (prev_pulse),
        .alert_req    (alert_req),
        .alert_page   (alert_page),
        .page_data    (page_data),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .page_idx     (page_idx),
        .alert_active (alert_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit n, input bit p, input bit a, input int ap);
        cyc++;
        if (r) begin
            m_mode = 0; m_man = 0; m_shown = 0; disp_valid = 0; sc = 0;
        end else begin
            disp_valid = 1;
            d_digit = (sc / RC) % 4;
            d_page  = m_shown;
            d_alert = (m_mode == 2);
            d_nib   = page_data[d_page*16 + d_digit*4 +: 4];
            sc++;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1 && a) begin
                m_mode = 2; m_shown = ap; m_astart = cyc;
            end else if (m_mode == 2) begin
                if (a) begin
                    m_shown = ap; m_astart = cyc;
                end else if (n || p || (cyc - m_astart == AC)) begin
                    m_mode = 1; m_shown = m_man;
                end
            end else if (n != p) begin
                m_man   = (m_man + (n ? 1 : NP - 1)) % NP;
                m_shown = m_man;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (disp_valid) begin
            e_an  = ~(4'b0001 << d_digit);
            e_seg = font[d_nib];
            e_dp  = (d_alert || d_digit == (d_page % 4)) ? 1'b0 : 1'b1;
        end else begin
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        end
        chk("page_idx", 32'(page_idx), 32'(m_shown));
        chk("alert_active", 32'(alert_active), 32'(m_mode == 2));
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
    endtask

    task automatic cycle(input bit r, input bit n, input bit p, input bit a, input int ap);
        rst = r; next_pulse = n; prev_pulse = p; alert_req = a; alert_page = PW'(ap);
        @(posedge clk);
        model_update(r, n, p, a, ap);
        #1;
        model_check();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int p = 0; p < NP; p++) page_data[p*16 +: 16] = 16'h1111 * 16'(p + 1);
        cyc = 0; sc = 0; m_mode = 0; m_man = 0; m_shown = 0; m_astart = 0;
        disp_valid = 0; d_alert = 0; d_digit = 0; d_page = 0; d_nib = '0;

        // Reset and release
        cycle(1, 0, 0, 0, 0);
        chk("rst_an", 32'(an), 32'h0000000f);
        chk("rst_seg", 32'(seg), 32'h0000007f);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rel_an", 32'(an), 32'h0000000e);
        chk("rel_seg", 32'(seg), 32'h00000079);
        chk("rel_dp", 32'(dp), 32'h0);
        idle(4);
        chk("scan_an1", 32'(an), 32'h0000000d);
        chk("scan_dp1", 32'(dp), 32'h1);
        idle(12);

        // Stepping
        cycle(0, 1, 0, 0, 0); chk("next1", 32'(page_idx), 32'd1);
        cycle(0, 1, 0, 0, 0); chk("next2", 32'(page_idx), 32'd2);
        cycle(0, 1, 0, 0, 0); chk("next3", 32'(page_idx), 32'd3);
        cycle(0, 1, 0, 0, 0); chk("next_wrap", 32'(page_idx), 32'd0);
        cycle(0, 0, 1, 0, 0); chk("prev_wrap", 32'(page_idx), 32'd3);
        cycle(0, 1, 1, 0, 0); chk("both", 32'(page_idx), 32'd3);
        cycle(0, 1, 0, 0, 0); cycle(0, 1, 0, 0, 0);
        chk("on_page1", 32'(page_idx), 32'd1);
        idle(3);

        // Alert on page 2 held exactly 20 cycles
        cycle(0, 0, 0, 1, 2);
        chk("alert_on", 32'(alert_active), 32'd1);
        chk("alert_page", 32'(page_idx), 32'd2);
        cycle(0, 0, 0, 0, 0);
        chk("alert_seg", 32'(seg), 32'h00000030);
        chk("alert_dp", 32'(dp), 32'h0);
        idle(18);
        chk("alert_hold19", 32'(alert_active), 32'd1);
        cycle(0, 0, 0, 0, 0);
        chk("alert_end", 32'(alert_active), 32'd0);
        chk("alert_back", 32'(page_idx), 32'd1);

        // Restart at alert cycle 10
        cycle(0, 0, 0, 1, 2);
        idle(9);
        cycle(0, 0, 0, 1, 3);
        chk("restart_page", 32'(page_idx), 32'd3);
        idle(19);
        chk("restart_hold", 32'(alert_active), 32'd1);
        cycle(0, 0, 0, 0, 0);
        chk("restart_end", 32'(alert_active), 32'd0);

        // Cancel with next_pulse: manual page not stepped
        cycle(0, 0, 0, 1, 2);
        idle(3);
        cycle(0, 1, 0, 0, 0);
        chk("cancel_page", 32'(page_idx), 32'd1);
        chk("cancel_mode", 32'(alert_active), 32'd0);

        // alert_req with next_pulse in MANUAL
        cycle(0, 1, 0, 1, 0);
        chk("prio_alert", 32'(alert_active), 32'd1);
        cycle(0, 0, 1, 0, 0);
        chk("prio_manual", 32'(page_idx), 32'd1);

        // Reset in the middle of an alert
        cycle(0, 0, 0, 1, 3);
        idle(4);
        cycle(1, 0, 0, 0, 0);
        chk("mid_rst_an", 32'(an), 32'h0000000f);
        chk("mid_rst_active", 32'(alert_active), 32'd0);
        cycle(0, 0, 0, 0, 0);
        chk("mid_rst_page", 32'(page_idx), 32'd0);

        // Random traffic against the model
        for (int p = 0; p < NP; p++) page_data[p*16 +: 16] = 16'($urandom);
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 250) == 0, ($urandom % 6) == 0, ($urandom % 7) == 0,
                  ($urandom % 30) == 0, int'($urandom_range(NP - 1, 0)));
            if ((i % 300) == 299)
                for (int p = 0; p < NP; p++) page_data[p*16 +: 16] = 16'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
